// File: rtl/data_sram_arbiter.sv
// Arbiter sharing the data SRAM port between the execute stage (fixed priority) and a DMA requester.
// Define ARB_STARVE_GUARD_EN to build the DMA anti-starvation counter and forced-grant state.
`timescale 1ns/1ps

module data_sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        es_req_valid,
  output logic        es_req_ready,
  input  logic [3:0]  es_req_wen,
  input  logic [31:0] es_req_addr,
  input  logic [31:0] es_req_wdata,
  output logic        es_rsp_valid,
  output logic [31:0] es_rsp_rdata,

  input  logic        dma_req_valid,
  output logic        dma_req_ready,
  input  logic [3:0]  dma_req_wen,
  input  logic [31:0] dma_req_addr,
  input  logic [31:0] dma_req_wdata,
  output logic        dma_rsp_valid,
  output logic [31:0] dma_rsp_rdata,

  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata
);

  logic w_es_gnt;
  logic w_dma_gnt;
  logic r_rsp_pend;
  logic r_rsp_owner;

`ifdef ARB_STARVE_GUARD_EN
  typedef enum logic {
    StEsPri,
    StDmaForce
  } state_e;

  localparam logic [3:0] LimitC = 4'(STARVE_LIMIT);

  state_e     r_state;
  state_e     w_state_d;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StEsPri;
      r_starve_cnt <= 4'h0;
    end else begin
      r_state      <= w_state_d;
      r_starve_cnt <= w_starve_cnt_d;
    end
  end

  always_comb begin
    w_es_gnt       = 1'b0;
    w_dma_gnt      = 1'b0;
    w_state_d      = r_state;
    w_starve_cnt_d = r_starve_cnt;

    // Valids are ignored while reset is held so the port shows its idle values.
    if (!reset) begin
      case (r_state)
        StEsPri: begin
          if (es_req_valid) begin
            w_es_gnt = 1'b1;
          end else if (dma_req_valid) begin
            w_dma_gnt = 1'b1;
          end
        end
        StDmaForce: w_dma_gnt = dma_req_valid;
        default: ;
      endcase
    end

    if (!dma_req_valid || w_dma_gnt) begin
      w_starve_cnt_d = 4'h0;
    end else if (r_starve_cnt < LimitC) begin
      w_starve_cnt_d = r_starve_cnt + 4'h1;
    end

    case (r_state)
      StEsPri: begin
        if (w_starve_cnt_d == LimitC) begin
          w_state_d = StDmaForce;
        end
      end
      StDmaForce: begin
        if (w_dma_gnt || !dma_req_valid) begin
          w_state_d = StEsPri;
        end
      end
      default: w_state_d = StEsPri;
    endcase
  end
`else
  logic w_unused_limit;
  assign w_unused_limit = ^4'(STARVE_LIMIT);

  // Strict execute-stage priority; DMA only fills idle cycles.
  assign w_es_gnt  = !reset && es_req_valid;
  assign w_dma_gnt = !reset && dma_req_valid && !es_req_valid;
`endif

  always_comb begin
    es_req_ready    = w_es_gnt;
    dma_req_ready   = w_dma_gnt;
    data_sram_en    = w_es_gnt || w_dma_gnt;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    if (w_es_gnt) begin
      data_sram_wen   = es_req_wen;
      data_sram_addr  = es_req_addr;
      data_sram_wdata = es_req_wdata;
    end else if (w_dma_gnt) begin
      data_sram_wen   = dma_req_wen;
      data_sram_addr  = dma_req_addr;
      data_sram_wdata = dma_req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_pend  <= 1'b0;
      r_rsp_owner <= 1'b0;
    end else begin
      r_rsp_pend <= (w_es_gnt && (es_req_wen == 4'h0)) ||
                    (w_dma_gnt && (dma_req_wen == 4'h0));
      if (w_es_gnt || w_dma_gnt) begin
        r_rsp_owner <= w_dma_gnt;
      end
    end
  end

  assign es_rsp_valid  = r_rsp_pend && !r_rsp_owner;
  assign dma_rsp_valid = r_rsp_pend && r_rsp_owner;
  assign es_rsp_rdata  = data_sram_rdata;
  assign dma_rsp_rdata = data_sram_rdata;

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Scoreboard bench for data_sram_arbiter: stimulus queues expected port/response records,
// a negedge monitor pops and compares them. Expectations follow ARB_STARVE_GUARD_EN.
`timescale 1ns/1ps

module tb_data_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        es_req_valid = 1'b0;
  logic        es_req_ready;
  logic [3:0]  es_req_wen = 4'h0;
  logic [31:0] es_req_addr = 32'h0;
  logic [31:0] es_req_wdata = 32'h0;
  logic        es_rsp_valid;
  logic [31:0] es_rsp_rdata;
  logic        dma_req_valid = 1'b0;
  logic        dma_req_ready;
  logic [3:0]  dma_req_wen = 4'h0;
  logic [31:0] dma_req_addr = 32'h0;
  logic [31:0] dma_req_wdata = 32'h0;
  logic        dma_rsp_valid;
  logic [31:0] dma_rsp_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata = 32'h0;

  data_sram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .es_req_valid   (es_req_valid),
    .es_req_ready   (es_req_ready),
    .es_req_wen     (es_req_wen),
    .es_req_addr    (es_req_addr),
    .es_req_wdata   (es_req_wdata),
    .es_rsp_valid   (es_rsp_valid),
    .es_rsp_rdata   (es_rsp_rdata),
    .dma_req_valid  (dma_req_valid),
    .dma_req_ready  (dma_req_ready),
    .dma_req_wen    (dma_req_wen),
    .dma_req_addr   (dma_req_addr),
    .dma_req_wdata  (dma_req_wdata),
    .dma_rsp_valid  (dma_rsp_valid),
    .dma_rsp_rdata  (dma_rsp_rdata),
    .data_sram_en   (data_sram_en),
    .data_sram_wen  (data_sram_wen),
    .data_sram_addr (data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: unwritten words read as addr ^ 0xA5A50000, except 0x100 reads 0xDEADBEEF.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return a ^ 32'hA5A5_0000;
  endfunction

  always @(posedge clk) begin
    if (data_sram_en) begin
      if (data_sram_wen == 4'h0) begin
        data_sram_rdata <= rd_word(data_sram_addr);
      end else begin
        logic [31:0] w;
        w = rd_word(data_sram_addr);
        for (int b = 0; b < 4; b++) begin
          if (data_sram_wen[b]) w[8*b +: 8] = data_sram_wdata[8*b +: 8];
        end
        mem[data_sram_addr] = w;
      end
    end
  end

  typedef struct packed {
    logic        es_rdy;
    logic        dma_rdy;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } port_t;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } rsp_t;

  port_t q_port[$];
  rsp_t  q_rsp[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    done = 1'b0;

  task automatic drive_cycle(input logic ev, input logic [3:0] ew, input logic [31:0] ea,
                             input logic [31:0] ed, input logic dv, input logic [3:0] dw,
                             input logic [31:0] da, input logic [31:0] dd, input int gnt,
                             input logic [31:0] exp_rd, input bit push_rsp, input bit rst_mid);
    port_t p;
    rsp_t  r;
    es_req_valid  = ev;
    es_req_wen    = ew;
    es_req_addr   = ea;
    es_req_wdata  = ed;
    dma_req_valid = dv;
    dma_req_wen   = dw;
    dma_req_addr  = da;
    dma_req_wdata = dd;
    p = '0;
    if (gnt == 1) p = '{es_rdy: 1'b1, dma_rdy: 1'b0, en: 1'b1, wen: ew, addr: ea, wdata: ed};
    if (gnt == 2) p = '{es_rdy: 1'b0, dma_rdy: 1'b1, en: 1'b1, wen: dw, addr: da, wdata: dd};
    q_port.push_back(p);
    if (push_rsp && gnt != 0 && p.wen == 4'h0) begin
      r.owner = (gnt == 2);
      r.data  = exp_rd;
      r.due   = cyc + 2;
      q_rsp.push_back(r);
    end
    @(negedge clk);
    #1;
    if (rst_mid) reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    port_t act;
    port_t exp;
    rsp_t  r;
    cyc = cyc + 1;
    if (q_port.size() > 0) begin
      exp = q_port.pop_front();
      act = '{es_rdy: es_req_ready, dma_rdy: dma_req_ready, en: data_sram_en,
              wen: data_sram_wen, addr: data_sram_addr, wdata: data_sram_wdata};
      checks = checks + 1;
      if (act !== exp) begin
        errors = errors + 1;
        $display("FAIL port cyc=%0d got rdy_es=%b rdy_dma=%b en=%b wen=%h addr=%h wdata=%h want rdy_es=%b rdy_dma=%b en=%b wen=%h addr=%h wdata=%h",
                 cyc, act.es_rdy, act.dma_rdy, act.en, act.wen, act.addr, act.wdata,
                 exp.es_rdy, exp.dma_rdy, exp.en, exp.wen, exp.addr, exp.wdata);
      end
    end
    if (q_rsp.size() > 0 && q_rsp[0].due == cyc) begin
      r = q_rsp.pop_front();
      checks = checks + 1;
      if ({es_rsp_valid, dma_rsp_valid} !== {!r.owner, r.owner} ||
          (r.owner ? dma_rsp_rdata : es_rsp_rdata) !== r.data) begin
        errors = errors + 1;
        $display("FAIL rsp cyc=%0d got es_v=%b dma_v=%b es_d=%h dma_d=%h want owner=%0d data=%h",
                 cyc, es_rsp_valid, dma_rsp_valid, es_rsp_rdata, dma_rsp_rdata, r.owner, r.data);
      end
    end else if (es_rsp_valid || dma_rsp_valid) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL rsp_unexpected cyc=%0d got es_v=%b dma_v=%b want both 0",
               cyc, es_rsp_valid, dma_rsp_valid);
    end
    if (done) begin
      checks = checks + 1;
      if (q_rsp.size() != 0 || q_port.size() != 0) begin
        errors = errors + 1;
        $display("FAIL leftover got rsp=%0d port=%0d want 0 0", q_rsp.size(), q_port.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no end of test want finish before 200us");
    $fatal(1);
  end

  initial begin
    int g;
    repeat (2) @(posedge clk);
    #1;
    // Valids present while reset is held: no grant, idle port.
    drive_cycle(1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0, 0, 32'h0, 1'b1, 1'b0);
    reset = 1'b0;

    drive_cycle(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    drive_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'hF, 32'h200, 32'h1234_5678, 2, 32'h0, 1'b1, 1'b0);
    drive_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 1'b0);

    drive_cycle(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    drive_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0, 2, 32'h1234_5678, 1'b1, 1'b0);
    drive_cycle(1'b1, 4'h0, 32'h104, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 32'hA5A5_0104, 1'b1, 1'b0);

    drive_cycle(1'b1, 4'h3, 32'h104, 32'h0000_CAFE, 1'b1, 4'h0, 32'h200, 32'h0, 1, 32'h0, 1'b1, 1'b0);
    drive_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'h200, 32'h0, 2, 32'h1234_5678, 1'b1, 1'b0);
    drive_cycle(1'b1, 4'h0, 32'h104, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 32'hA5A5_CAFE, 1'b1, 1'b0);

    // Continuous contention.
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      g = ((i % 5) == 4) ? 2 : 1;
`else
      g = 1;
`endif
      drive_cycle(1'b1, 4'h0, 32'h300 + 32'(4 * i), 32'h0, 1'b1, 4'h0, 32'h400, 32'h0, g,
                  (g == 2) ? 32'hA5A5_0400 : (32'hA5A5_0300 + 32'(4 * i)), 1'b1, 1'b0);
    end
    drive_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 1'b0);

    // Granted read then reset before the response edge: response must be dropped.
    drive_cycle(1'b1, 4'h0, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1, 32'h0, 1'b0, 1'b1);
    drive_cycle(1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 4'h0, 32'h404, 32'h0, 0, 32'h0, 1'b1, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      g = (i == 4) ? 2 : 1;
`else
      g = 1;
`endif
      drive_cycle(1'b1, 4'h0, 32'h500 + 32'(4 * i), 32'h0, 1'b1, 4'h0, 32'h404, 32'h0, g,
                  (g == 2) ? 32'hA5A5_0404 : (32'hA5A5_0500 + 32'(4 * i)), 1'b1, 1'b0);
    end
    drive_cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 1'b0);
    done = 1'b1;
  end

endmodule
